token_run_encoder: RTL and testbench

TOKEN_RUN_ENCODER -- requirements
Module: token_run_encoder

---
 rtl/token_pkg.sv | 13 +
 rtl/token_fifo.sv | 56 +++++
 rtl/token_run_encoder.sv | 80 ++++++++
 tb/tb_token_run_encoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// Shared defaults and the run-length entry layout for the token run encoder.
package token_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_DEPTH = 4;

    // One completed run: saturation flag above the run length
    typedef struct packed {
        logic                 sat;
        logic [DEF_CNT_W-1:0] len;
    } run_entry_t;

endpackage

// File: rtl/token_fifo.sv
// First-word-fall-through FIFO of run entries with wrapping pointers and
// a separate occupancy count so full and empty are never ambiguous.
module token_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = token_pkg::run_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));

    // A pop frees the head on the same edge, so a full FIFO can still take a push
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry is shown straight from storage; zeros while empty
    assign dout = empty ? '0 : mem_q[rptr_q];

    // Storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/token_run_encoder.sv
// Counts runs of 1s on a serial token stream and queues each finished run
// (length plus saturation flag) for a ready/valid consumer.
module token_run_encoder
    import token_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_len,
    output logic             out_sat,
    output logic             drop_err
);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] len;
    } ent_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             drop_q;
    logic             push, pop, full, empty;
    ent_t             din, dout;

    assign push      = !in_bit && (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign din       = '{sat: sat_q, len: cnt_q};
    assign out_valid = !empty;
    assign out_len   = dout.len;
    assign out_sat   = dout.sat;
    assign drop_err  = drop_q;

    // Run counter: saturate at max and remember it; a 0 closes the run
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (in_bit) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    // Run state and sticky drop flag; the reset edge ignores in_bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sat_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (push && full && !pop) drop_q <= 1'b1;
        end
    end

    token_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ent_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_token_run_encoder.sv
// Bench for token_run_encoder: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_token_run_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXC  = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_bit = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [CNT_W-1:0] out_len;
    logic             out_sat;
    logic             drop_err;

    int errors = 0;
    int checks = 0;

    // model state: entries stored as len*2 + sat
    int mq[$];
    int mcnt = 0;
    bit msat = 0;
    bit mdrop = 0;
    // entries the bench saw leave the DUT
    int got[$];

    token_run_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_len   (out_len),
        .out_sat   (out_sat),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic chk_list(string name, input int exp[$]);
        chk({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s len[%0d]", name, i), got[i] / 2, exp[i] / 2);
            chk($sformatf("%s sat[%0d]", name, i), got[i] % 2, exp[i] % 2);
        end
    endtask

    // Reference model: runs, bounded queue, sticky drop
    always @(posedge clk) begin : model
        bit pop, push;
        int ent;
        if (rst) begin
            mq.delete();
            mcnt  = 0;
            msat  = 0;
            mdrop = 0;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = 0;
            ent  = 0;
            if (in_bit) begin
                if (mcnt == MAXC) msat = 1;
                else              mcnt++;
            end else if (mcnt != 0) begin
                push = 1;
                ent  = mcnt * 2 + int'(msat);
                mcnt = 0;
                msat = 0;
            end
            if (push && mq.size() == DEPTH && !pop) begin
                mdrop = 1;
                push  = 0;
            end
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(ent);
        end
    end

    // Compare DUT against model on every cycle, away from the edge
    always @(negedge clk) begin : compare
        int ev, el, es;
        ev = (mq.size() != 0) ? 1 : 0;
        el = ev ? mq[0] / 2 : 0;
        es = ev ? mq[0] % 2 : 0;
        chk("out_valid", int'(out_valid), ev);
        chk("out_len",   int'(out_len),   el);
        chk("out_sat",   int'(out_sat),   es);
        chk("drop_err",  int'(drop_err),  int'(mdrop));
        if (out_valid && out_ready) got.push_back(int'(out_len) * 2 + int'(out_sat));
    end

    task automatic cyc(input bit b, input bit r, input bit rs = 1'b0);
        in_bit    = b;
        out_ready = r;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic run_str(input string s, input bit r);
        for (int i = 0; i < s.len(); i++) cyc(s[i] == 8'h31, r);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        got.delete();
    endtask

    initial begin
        // reset with in_bit high: must be ignored
        do_reset();
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_len",   int'(out_len),   0);
        chk("reset drop_err",  int'(drop_err),  0);

        // mixed runs, consumer always ready
        run_str("11011011110111111001111110", 1'b1);
        chk("pattern valid latency", int'(out_valid), 1);
        chk("pattern last len", int'(out_len), 6);
        repeat (3) cyc(1'b0, 1'b1);
        chk_list("pattern", '{4, 4, 8, 12, 12});
        chk("pattern drop_err", int'(drop_err), 0);

        // saturation then a short run
        got.delete();
        repeat (300) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        run_str("1110", 1'b1);
        repeat (3) cyc(1'b0, 1'b1);
        chk_list("saturate", '{511, 6});

        // overflow while stalled, then drain
        do_reset();
        for (int i = 0; i < 4; i++) run_str("10", 1'b0);
        chk("fill drop_err before", int'(drop_err), 0);
        run_str("10", 1'b0);
        chk("fill drop_err after", int'(drop_err), 1);
        repeat (8) cyc(1'b0, 1'b1);
        chk_list("drain", '{2, 2, 2, 2});
        chk("drain drop_err sticky", int'(drop_err), 1);

        // push into full FIFO with a same-edge pop
        do_reset();
        for (int i = 0; i < 4; i++) run_str("10", 1'b0);
        run_str("11111", 1'b0);
        cyc(1'b0, 1'b1);
        repeat (6) cyc(1'b0, 1'b1);
        chk_list("full push+pop", '{2, 2, 2, 2, 10});
        chk("full push+pop drop_err", int'(drop_err), 0);

        // reset mid-run with entries pending
        do_reset();
        run_str("1010", 1'b0);
        run_str("1111111", 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        chk("midreset out_valid", int'(out_valid), 0);
        got.delete();
        run_str("1110", 1'b1);
        repeat (4) cyc(1'b0, 1'b1);
        chk_list("midreset", '{6});

        // random traffic against the model, with drops and saturation
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit b;
            if ((i / 500) % 2 == 1) b = ($urandom_range(0, 15) != 0);
            else                    b = ($urandom_range(0, 3) != 0);
            cyc(b, $urandom_range(0, 2) == 0);
        end
        repeat (10) cyc(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
